// File: rtl/uart_sram_master.sv
// uart_sram_master
// ----------------
// Debug bus initiator driven by a UART byte stream. Decodes 'R'/'W' commands
// (opcode, little-endian address, little-endian write data), performs one
// full-word access on an SRAM-style port and returns the response bytes
// through the transmit handshake.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   rx_data/rx_ready: received byte and its one-cycle strobe
//   tx_data/tx_valid/tx_ready : transmit byte handshake
//   addra/dina/douta: bus address (bits [2:0] = 0), write data, read data
//   ena/wea         : access strobe and byte write enables
//   busy            : high whenever the FSM is not IDLE
//   dbg_state       : current FSM state encoding
//
// Handshake: a byte is transferred in each cycle where tx_valid & tx_ready.
// Once tx_valid is raised it stays high with tx_data constant until that
// transfer happens; tx_data advances only in the cycle after a transfer.
// rx_ready is a pure strobe with no back-pressure; bytes arriving while the
// FSM is not collecting command bytes are dropped.
module uart_sram_master #(
  parameter int LEN_ADDR       = 64,
  parameter int LEN_DATA       = 64,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [LEN_ADDR-1:0]   addra,
  output logic [LEN_DATA-1:0]   dina,
  input  logic [LEN_DATA-1:0]   douta,
  output logic                  ena,
  output logic [LEN_DATA/8-1:0] wea,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int NA = LEN_ADDR / 8;
  localparam int ND = LEN_DATA / 8;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    ADDR_LAST = 8'(NA - 1);
  localparam logic [7:0]    DATA_LAST = 8'(ND - 1);

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_RCAP  = 3'd5,
    S_SEND  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_is_write;
  logic [7:0]          r_cnt;
  logic [TW-1:0]       r_tmo;
  // Shift registers hold all but the final byte; the final byte is merged
  // straight from rx_data when the field completes.
  logic [LEN_ADDR-9:0] r_addr;
  logic [LEN_DATA-9:0] r_wdat;
  logic [LEN_DATA-9:0] r_tx_shift;
  logic [7:0]          r_tx_left;

  logic [LEN_ADDR-1:0]   r_addra;
  logic [LEN_DATA-1:0]   r_dina;
  logic                  r_ena;
  logic [LEN_DATA/8-1:0] r_wea;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_busy;

  logic                w_accept;
  logic                w_counting;
  logic                w_timeout;
  logic                w_known_op;
  logic [LEN_ADDR-1:0] w_addr_full;
  logic [LEN_DATA-1:0] w_data_full;

  assign w_accept    = r_tx_valid & tx_ready;
  assign w_counting  = (r_state == S_ADDR) || (r_state == S_WDATA);
  assign w_timeout   = w_counting && (r_tmo == TMO_LAST);
  assign w_known_op  = (rx_data == OP_READ) || (rx_data == OP_WRITE);
  assign w_addr_full = {rx_data, r_addr};
  assign w_data_full = {rx_data, r_wdat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A received byte takes priority over an expiring timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_ready) w_next = w_known_op ? S_ADDR : S_SEND;
      end
      S_ADDR: begin
        if (rx_ready) begin
          if (r_cnt == ADDR_LAST) w_next = r_is_write ? S_WDATA : S_READ;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_ready) begin
          if (r_cnt == DATA_LAST) w_next = S_WRITE;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_WRITE: w_next = S_SEND;
      S_READ:  w_next = S_RCAP;
      S_RCAP:  w_next = S_SEND;
      S_SEND: begin
        if (w_accept && (r_tx_left == 8'd0)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Idle-gap counter between command bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (rx_ready || !w_counting || w_timeout) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write <= 1'b0;
      r_cnt      <= 8'd0;
      r_addr     <= '0;
      r_wdat     <= '0;
      r_tx_shift <= '0;
      r_tx_left  <= 8'd0;
      r_addra    <= '0;
      r_dina     <= '0;
      r_ena      <= 1'b0;
      r_wea      <= '0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Strobes follow the next state so they line up with the state itself.
      r_ena      <= (w_next == S_WRITE) || (w_next == S_READ);
      r_wea      <= (w_next == S_WRITE) ? '1 : '0;
      r_tx_valid <= (w_next == S_SEND);
      r_busy     <= (w_next != S_IDLE);

      case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_is_write <= (rx_data == OP_WRITE);
            r_cnt      <= 8'd0;
            if (!w_known_op) begin
              r_tx_data <= RSP_BAD;
              r_tx_left <= 8'd0;
            end
          end
        end
        S_ADDR: begin
          if (rx_ready) begin
            r_addr <= w_addr_full[LEN_ADDR-1:8];
            if (r_cnt == ADDR_LAST) begin
              r_cnt   <= 8'd0;
              r_addra <= w_addr_full & ~LEN_ADDR'(7);
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (w_timeout) begin
            r_cnt <= 8'd0;
          end
        end
        S_WDATA: begin
          if (rx_ready) begin
            r_wdat <= w_data_full[LEN_DATA-1:8];
            if (r_cnt == DATA_LAST) begin
              r_cnt  <= 8'd0;
              r_dina <= w_data_full;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else if (w_timeout) begin
            r_cnt <= 8'd0;
          end
        end
        S_WRITE: begin
          r_tx_data <= RSP_OK;
          r_tx_left <= 8'd0;
        end
        S_RCAP: begin
          // douta is valid in the cycle after the READ strobe.
          r_tx_data  <= douta[7:0];
          r_tx_shift <= douta[LEN_DATA-1:8];
          r_tx_left  <= DATA_LAST;
        end
        S_SEND: begin
          if (w_accept && (r_tx_left != 8'd0)) begin
            r_tx_data  <= r_tx_shift[7:0];
            r_tx_shift <= r_tx_shift >> 8;
            r_tx_left  <= r_tx_left - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign addra     = r_addra;
  assign dina      = r_dina;
  assign ena       = r_ena;
  assign wea       = r_wea;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_sram_master.sv
// Directed bench for uart_sram_master: write, read, stalled read, unknown
// opcode, inter-byte timeout, byte drop during SEND and reset mid-response.
module tb_uart_sram_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] addra;
  logic [63:0] dina;
  logic [63:0] douta;
  logic        ena;
  logic [7:0]  wea;
  logic        busy;
  logic [2:0]  dbg_state;

  uart_sram_master #(
    .LEN_ADDR(64),
    .LEN_DATA(64),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .addra(addra),
    .dina(dina),
    .douta(douta),
    .ena(ena),
    .wea(wea),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus model ----------------
  // Read data appears only in the cycle after an ena cycle.
  logic [63:0] rd_val;
  always @(posedge clk) douta <= ena ? rd_val : 64'h0BAD_0BAD_0BAD_0BAD;

  // ---------------- tx_ready driver ----------------
  int ready_mode; // 0 low, 1 high, 2 random
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          got_rd = 0;
  int          cyc = 0, ena_cnt = 0, ena_cyc = 0, rise_cyc = 0;
  int          stab_err = 0, wea_err = 0;
  logic [63:0] last_addr = '0, last_din = '0;
  logic [7:0]  last_wea = '0;
  logic        prev_valid = 1'b0, prev_acc = 1'b0, prev_ena = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_valid <= 1'b0;
      prev_acc   <= 1'b0;
      prev_ena   <= 1'b0;
    end else begin
      if (prev_ena && (wea != 8'h00)) wea_err <= wea_err + 1;
      if (ena) begin
        ena_cnt   <= ena_cnt + 1;
        ena_cyc   <= cyc;
        last_addr <= addra;
        last_din  <= dina;
        last_wea  <= wea;
      end
      if (tx_valid && !prev_valid) rise_cyc <= cyc;
      if (prev_valid && !prev_acc && (!tx_valid || (tx_data !== prev_data)))
        stab_err <= stab_err + 1;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      prev_valid <= tx_valid;
      prev_acc   <= tx_valid && tx_ready;
      prev_data  <= tx_data;
      prev_ena   <= ena;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_exp_word(input logic [63:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // Waits (bounded) for as many TX bytes as expected, then compares in order.
  task automatic check_tx(input string tag);
    int n;
    int k;
    logic [7:0] g;
    n = exp_q.size();
    k = 0;
    while (((got_q.size() - got_rd) < n) && (k < 400)) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_count"}, 64'(got_q.size() - got_rd), 64'(n));
    while (exp_q.size() > 0) begin
      if (got_rd < got_q.size()) begin
        g = got_q[got_rd];
        got_rd++;
      end else begin
        g = 8'hxx;
      end
      check({tag, "_byte"}, {56'd0, g}, {56'd0, exp_q.pop_front()});
    end
  endtask

  task automatic check_reset_vals();
    check("rst_ena",      {63'd0, ena},      64'd0);
    check("rst_wea",      {56'd0, wea},      64'd0);
    check("rst_addra",    addra,             64'd0);
    check("rst_dina",     dina,              64'd0);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_tx_data",  {56'd0, tx_data},  64'd0);
    check("rst_busy",     {63'd0, busy},     64'd0);
    check("rst_state",    {61'd0, dbg_state}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int base;
  int k;
  int got_base;

  initial begin
    rx_data    = 8'h00;
    rx_ready   = 1'b0;
    rd_val     = 64'h0;
    ready_mode = 1;
    rst        = 1'b1;
    idle(3);
    check_reset_vals();
    rst = 1'b0;
    idle(2);

    // Write
    base = ena_cnt;
    check("wr_busy_pre", {63'd0, busy}, 64'd0);
    send_byte(8'h57);
    check("wr_busy_op", {63'd0, busy}, 64'd1);
    send_word(64'h0000_0000_6000_0008);
    send_word(64'h1122_3344_5566_7788);
    exp_q.push_back(8'h4B);
    check_tx("wr");
    check("wr_ena_cnt", 64'(ena_cnt - base), 64'd1);
    check("wr_addra", last_addr, 64'h6000_0008);
    check("wr_dina", last_din, 64'h1122_3344_5566_7788);
    check("wr_wea", {56'd0, last_wea}, 64'hFF);
    check("wr_latency", 64'(rise_cyc - ena_cyc), 64'd1);
    idle(2);
    check("wr_wea_after", {56'd0, wea}, 64'h00);
    check("wr_busy_end", {63'd0, busy}, 64'd0);
    check("wr_state_end", {61'd0, dbg_state}, 64'd0);

    // Read
    base   = ena_cnt;
    rd_val = 64'hDEAD_BEEF_CAFE_F00D;
    send_byte(8'h52);
    send_word(64'h0000_0000_0000_000F);
    push_exp_word(64'hDEAD_BEEF_CAFE_F00D);
    check_tx("rd");
    check("rd_ena_cnt", 64'(ena_cnt - base), 64'd1);
    check("rd_addra", last_addr, 64'h8);
    check("rd_wea", {56'd0, last_wea}, 64'h00);
    check("rd_latency", 64'(rise_cyc - ena_cyc), 64'd2);

    // Read with random tx_ready stalls
    ready_mode = 2;
    rd_val     = 64'h0123_4567_89AB_CDEF;
    send_byte(8'h52);
    send_word(64'h0000_0000_0000_0010);
    push_exp_word(64'h0123_4567_89AB_CDEF);
    check_tx("rds");
    check("rds_addra", last_addr, 64'h10);
    ready_mode = 1;
    idle(2);

    // Unknown opcode, then a normal read
    base = ena_cnt;
    send_byte(8'h41);
    exp_q.push_back(8'h3F);
    check_tx("unk");
    idle(2);
    check("unk_ena_cnt", 64'(ena_cnt - base), 64'd0);
    check("unk_state", {61'd0, dbg_state}, 64'd0);
    check("unk_busy", {63'd0, busy}, 64'd0);
    rd_val = 64'hA5A5_5A5A_0F0F_F0F0;
    send_byte(8'h52);
    send_word(64'h0000_0000_0000_0020);
    push_exp_word(64'hA5A5_5A5A_0F0F_F0F0);
    check_tx("unk_rd");
    check("unk_rd_addra", last_addr, 64'h20);

    // Timeout after a partial write command
    idle(2);
    base     = ena_cnt;
    got_base = got_q.size();
    send_byte(8'h57);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(10);
    check("tmo_busy_early", {63'd0, busy}, 64'd1);
    idle(10);
    check("tmo_busy", {63'd0, busy}, 64'd0);
    check("tmo_state", {61'd0, dbg_state}, 64'd0);
    check("tmo_ena_cnt", 64'(ena_cnt - base), 64'd0);
    check("tmo_no_tx", 64'(got_q.size() - got_base), 64'd0);
    rd_val = 64'h1357_9BDF_2468_ACE0;
    send_byte(8'h52);
    send_word(64'h0000_0000_0000_0028);
    push_exp_word(64'h1357_9BDF_2468_ACE0);
    check_tx("tmo_rd");
    check("tmo_rd_addra", last_addr, 64'h28);

    // Byte dropped while the response is pending
    ready_mode = 0;
    base       = ena_cnt;
    rd_val     = 64'h8877_6655_4433_2211;
    send_byte(8'h52);
    send_word(64'h0000_0000_0000_0030);
    k = 0;
    while (!tx_valid && (k < 50)) begin
      @(posedge clk); #1;
      k++;
    end
    check("drop_valid", {63'd0, tx_valid}, 64'd1);
    send_byte(8'h57);
    idle(2);
    check("drop_state", {61'd0, dbg_state}, 64'd6);
    check("drop_tx_data", {56'd0, tx_data}, 64'h11);
    ready_mode = 1;
    push_exp_word(64'h8877_6655_4433_2211);
    check_tx("drop");
    idle(2);
    check("drop_state_end", {61'd0, dbg_state}, 64'd0);
    check("drop_busy_end", {63'd0, busy}, 64'd0);
    check("drop_ena_cnt", 64'(ena_cnt - base), 64'd1);

    // Reset while the 5th response byte is presented
    rd_val   = 64'hDEAD_BEEF_CAFE_F00D;
    got_base = got_q.size();
    send_byte(8'h52);
    send_word(64'h0000_0000_0000_0040);
    k = 0;
    while (((got_q.size() - got_base) < 4) && (k < 100)) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst5_tx_data", {56'd0, tx_data}, 64'hEF);
    check("rst5_tx_valid", {63'd0, tx_valid}, 64'd1);
    rst = 1'b1;
    #1;
    check_reset_vals();
    idle(3);
    rst = 1'b0;
    idle(20);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hCA);
    check_tx("rst5");
    check("rst5_no_more_tx", 64'(got_q.size() - got_base), 64'd4);
    check("rst5_busy", {63'd0, busy}, 64'd0);

    check("tx_stability", 64'(stab_err), 64'd0);
    check("wea_clear", 64'(wea_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_sram_master.md
# uart_sram_master

UART-driven debug initiator for the 64-bit SRAM-style memory bus. It consumes received bytes from `uart_phy`, decodes read and write commands, and issues single-word accesses on an `addra/dina/douta/ena/wea` port. That port attaches to the same crossbars as the pipeline's data port. Responses go back out through the `uart_phy` transmit handshake, which allows host-side program loading and memory/MMIO peeking without the CPU.

## Interface
- `LEN_ADDR`, 64: bus address width; multiple of 8.
- `LEN_DATA`, 64: bus data width; multiple of 8.
- `TIMEOUT_CYCLES`, 100000000: idle cycles allowed between bytes of one command before it is abandoned.

- `clk` input 1: single clock for all logic.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input 8: received byte from `uart_phy`.
- `rx_ready` input 1: one-cycle pulse; `rx_data` is valid this cycle.
- `tx_data` output 8: byte to transmit.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: PHY accepts the byte in any cycle where `tx_valid & tx_ready`.
- `addra` output LEN_ADDR: bus address, with bits [2:0] always 0.
- `dina` output LEN_DATA: write data.
- `douta` input LEN_DATA: read data, valid one cycle after an `ena` cycle.
- `ena` output 1: access strobe.
- `wea` output LEN_DATA/8: byte write enables.
- `busy` output 1: high in every state except IDLE.

## Operation
- Command framing: one opcode byte, then the address in little-endian byte order.
  - Opcode 0x52 ('R'): LEN_ADDR/8 address bytes follow.
  - Opcode 0x57 ('W'): LEN_ADDR/8 address bytes follow, then LEN_DATA/8 data bytes, also little-endian.
- Address bits [2:0] are forced to 0; accesses are full words only.
- Responses:
  - Write: a single byte 0x4B ('K') after the bus write.
  - Read: LEN_DATA/8 bytes of captured `douta`, least-significant byte first.
  - Unknown opcode: a single byte 0x3F ('?'), then return to IDLE.
- FSM states and transitions:
  - IDLE: a byte is received. Opcode 'R' or 'W' goes to ADDR; any other value loads '?' and goes to SEND.
  - ADDR: shift in address bytes. After the last byte, 'W' goes to WDATA and 'R' goes to READ.
  - WDATA: shift in data bytes. After the last byte, go to WRITE.
  - WRITE: one cycle with `ena`=1 and `wea`=all ones. Load 'K' and go to SEND.
  - READ: one cycle with `ena`=1 and `wea`=0. Go to RCAP.
  - RCAP: latch `douta` into the response shift register and go to SEND.
  - SEND: hold `tx_valid`=1 with a stable `tx_data` until accepted. On each accept, shift to the next byte. After the last accept, go to IDLE.
- Bytes arriving with `rx_ready` in WRITE, READ, RCAP or SEND are dropped, and the state is unaffected.
- The timeout counter is cleared on every `rx_ready`. It counts only in ADDR and WDATA. When it reaches TIMEOUT_CYCLES-1, the state returns to IDLE and the partial command is discarded with no response.
- A byte and a timeout in the same cycle: the byte wins and the counter clears.

## Timing
- Reset values:
  - `ena`=0, `wea`=0, `addra`=0, `dina`=0.
  - `tx_valid`=0, `tx_data`=0, `busy`=0.
  - State IDLE, byte counter 0, timeout counter 0.
- Reset mid-command or mid-send aborts immediately. No further bus access or byte is emitted.
- All outputs are registered.
- `ena` is high for exactly one cycle per command, and `addra`/`dina`/`wea` are valid in that cycle. They hold their values afterwards, but `wea` returns to 0 in the cycle after the write.
- Read path:
  - `ena` is asserted at cycle T.
  - `douta` is sampled at the end of T+1 (RCAP).
  - `tx_valid` first rises at T+2.
- Write path: `ena` is asserted at cycle T, and `tx_valid` rises at T+1 with 'K'.
- `tx_valid` never drops without an accept. `tx_data` changes only in the cycle following an accept.
- Consecutive accepts in back-to-back cycles are supported, at one byte per accepting cycle.
- `busy` rises the cycle after the opcode byte and falls the cycle after the final accept.

## Test plan
- **Write:** send 57, then address 08 00 00 60 00 00 00 00, then data 88 77 66 55 44 33 22 11.
  - One `ena` cycle with `addra`=0x60000008, `dina`=0x1122334455667788, `wea`=0xFF.
  - Then `tx_data`=0x4B.
- **Read:** send 52, then address 0F 00 00 00 00 00 00 00, with the bus model returning 0xDEADBEEFCAFEF00D.
  - One `ena` cycle with `addra`=0x8 (low bits cleared) and `wea`=0.
  - TX bytes are 0D F0 FE CA EF BE AD DE.
  - Repeat with `tx_ready` stalling randomly; the byte order is unchanged and no byte is duplicated.
- **Unknown opcode:** send 0x41.
  - TX emits 0x3F with no `ena`, then the block is in IDLE.
  - A following 'R' command works normally.
- **Timeout:** use TIMEOUT_CYCLES=16, send 57 plus 3 address bytes, then wait 20 cycles.
  - `busy` falls, with no `ena` and no TX.
  - A new 'R' command then completes correctly.
- **Drop during SEND:** while the read response is pending with `tx_ready`=0, pulse `rx_ready` with 0x57.
  - The byte is ignored, the response completes, and the state is IDLE.
- **Async reset:** assert `rst` during the 5th response byte.
  - Outputs go to their reset values immediately, with no further TX.
